// File: rtl/ram_fifo_pkg.sv
// Shared sizing and types for the RAM-backed FIFO controller.
package ram_fifo_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DEPTH  = 2 ** ADDR_W;

    typedef logic [ADDR_W:0] level_t;
    typedef logic [1:0]      occ_t;

endpackage

// File: rtl/ram_fifo_outbuf.sv
// Two-entry output buffer fed by a 1-cycle-latency RAM read port.
// Returning read data is forwarded directly when the buffer is empty.
module ram_fifo_outbuf #(
    parameter int unsigned DATA_W = ram_fifo_pkg::DATA_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              rd_issue,
    input  logic [DATA_W-1:0] ram_data_out,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              pop,
    output logic [1:0]        occupancy
);
    import ram_fifo_pkg::*;

    logic [DATA_W-1:0] entry_q [2];
    logic              head_q;
    logic              tail_q;
    occ_t              count_q;
    logic              inflight_q;

    logic has_buf;
    logic push_buf;
    logic pop_buf;

    assign has_buf   = (count_q != '0);
    assign out_valid = reset_n && (has_buf || inflight_q);
    assign out_data  = !reset_n   ? '0 :
                       has_buf    ? entry_q[head_q] :
                       inflight_q ? ram_data_out : '0;
    assign pop       = out_valid && out_ready;
    // Returning data bypasses storage only when it is consumed on arrival.
    assign push_buf  = inflight_q && !(pop && !has_buf);
    assign pop_buf   = pop && has_buf;
    assign occupancy = count_q + occ_t'(inflight_q);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            entry_q[0] <= '0;
            entry_q[1] <= '0;
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            count_q    <= '0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= rd_issue;
            if (push_buf) begin
                entry_q[tail_q] <= ram_data_out;
                tail_q          <= ~tail_q;
            end
            if (pop_buf) begin
                head_q <= ~head_q;
            end
            count_q <= count_q + occ_t'(push_buf) - occ_t'(pop_buf);
        end
    end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller driving an external synchronous dual-port RAM,
// with a 2-entry output buffer so reads keep one pop per cycle.
module ram_fifo_ctrl #(
    parameter int unsigned DATA_W = ram_fifo_pkg::DATA_W,
    parameter int unsigned ADDR_W = ram_fifo_pkg::ADDR_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              ram_write_en,
    output logic [ADDR_W-1:0] ram_write_address,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_read_en,
    output logic [ADDR_W-1:0] ram_read_address,
    input  logic [DATA_W-1:0] ram_data_out,
    output logic [ADDR_W:0]   ram_level
);
    import ram_fifo_pkg::*;

    localparam int unsigned LVL_W    = ADDR_W + 1;
    localparam int unsigned DEPTH_L  = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FULL_LVL = LVL_W'(DEPTH_L);

    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [ADDR_W:0]   level_q;

    logic       push;
    logic       issue;
    logic       pop;
    logic [1:0] occupancy;

    assign in_ready = reset_n && (level_q != FULL_LVL);
    assign push     = in_valid && in_ready;
    // Read issue looks at the registered level, so it never chases this cycle's write.
    assign issue    = reset_n && (level_q != '0) &&
                      ((3'(occupancy) - 3'(pop)) < 3'd2);

    assign ram_write_en      = push;
    assign ram_write_address = wr_ptr_q;
    assign ram_data_in       = in_data;
    assign ram_read_en       = issue;
    assign ram_read_address  = rd_ptr_q;
    assign ram_level         = level_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            end
            if (issue) begin
                rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
            end
            level_q <= level_q + LVL_W'(push) - LVL_W'(issue);
        end
    end

    ram_fifo_outbuf #(
        .DATA_W (DATA_W)
    ) u_outbuf (
        .clock        (clock),
        .reset_n      (reset_n),
        .rd_issue     (issue),
        .ram_data_out (ram_data_out),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .pop          (pop),
        .occupancy    (occupancy)
    );

endmodule

// File: doc/ram_fifo_ctrl.md
RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 Parameter: DATA_W, 8, data width in bits.
REQ-002 Parameter: ADDR_W, 8, RAM address width in bits; RAM depth DEPTH = 2**ADDR_W = 256.
REQ-003 Port: clock  input  1  single clock; all logic on posedge clock.
REQ-004 Port: reset_n  input  1  reset, synchronous, active-low.
REQ-005 Port: in_valid  input  1  producer offers in_data.
REQ-006 Port: in_ready  output  1  controller accepts; push occurs when in_valid && in_ready.
REQ-007 Port: in_data  input  DATA_W  push data.
REQ-008 Port: out_valid  output  1  out_data holds the oldest entry.
REQ-009 Port: out_ready  input  1  consumer accepts; pop occurs when out_valid && out_ready.
REQ-010 Port: out_data  output  DATA_W  pop data.
REQ-011 Port: ram_write_en  output  1  RAM write strobe.
REQ-012 Port: ram_write_address  output  ADDR_W  RAM write address.
REQ-013 Port: ram_data_in  output  DATA_W  RAM write data.
REQ-014 Port: ram_read_en  output  1  RAM read strobe.
REQ-015 Port: ram_read_address  output  ADDR_W  RAM read address.
REQ-016 Port: ram_data_out  input  DATA_W  RAM read data, valid exactly 1 cycle after ram_read_en.
REQ-017 Port: ram_level  output  ADDR_W+1  entries held in RAM (0..256), excluding output buffer.

Function
REQ-018 Controller SHALL be the initiator for an external synchronous dual-port RAM (one write port, one read port, 1-cycle read latency) and present it as a FIFO.
REQ-019 in_ready SHALL equal (ram_level != DEPTH) && reset_n; on push, ram_write_en=1, ram_write_address=wr_ptr, ram_data_in=in_data combinationally in the same cycle.
REQ-020 wr_ptr and rd_ptr SHALL be ADDR_W bits, increment by 1 per write/read issue, wrap 255 -> 0.
REQ-021 Output buffer SHALL hold 2 entries; reads issue when ram_level != 0 && (buffered entries + inflight read - pop this cycle) < 2.
REQ-022 On read issue: ram_read_en=1, ram_read_address=rd_ptr; ram_data_out SHALL be captured into the output buffer next cycle.
REQ-023 ram_level next = ram_level + push - read_issue; simultaneous push and read issue leaves it unchanged.
REQ-024 Read issue SHALL use ram_level before the current push, so a read never targets the address written in the same cycle.
REQ-025 Latency: push into an empty FIFO at cycle t -> read issue t+1 -> out_valid=1 at t+2.
REQ-026 Throughput: sustained push and pop at 1 entry/cycle with no bubbles once primed.
REQ-027 Total capacity SHALL be DEPTH+2; in_ready deasserts only when ram_level == 256.
REQ-028 out_data SHALL remain stable while out_valid && !out_ready.
REQ-029 Order SHALL be strict FIFO; no data loss or duplication at any wrap-around.

Reset
REQ-030 While reset_n=0 at posedge: wr_ptr=0, rd_ptr=0, ram_level=0, buffer empty, inflight cleared; out_valid=0, in_ready=0, ram_write_en=0, ram_read_en=0, out_data=0.
REQ-031 Reset mid-operation SHALL discard all contents, including a read in flight; its returning data is ignored.
REQ-032 RAM contents need no initialisation; controller never reads an unwritten address.

Structure
REQ-033 Package ram_fifo_pkg SHALL hold DATA_W, ADDR_W, DEPTH defaults and the level type (ADDR_W+1 bits).
REQ-034 One sub-module, ram_fifo_outbuf, SHALL implement the 2-entry output buffer with valid/ready and inflight tracking.

Verification
REQ-035 Reset, then push 0x11 at cycle 0 with out_ready=1 -> ram_read_en at cycle 1, out_valid=1 with out_data=0x11 at cycle 2.
REQ-036 Push 258 values 0..255,0xAA,0xBB with out_ready=0 -> in_ready=0 after the 258th, ram_level=256; then pop all -> values in order.
REQ-037 Continuous push and pop for 1000 cycles with incrementing data -> one pop per cycle after priming, pointers wrap, order intact.
REQ-038 Hold out_ready=0 for 5 cycles with out_valid=1 -> out_data unchanged, no extra ram_read_en beyond buffer space.
REQ-039 Assert reset_n=0 for 1 cycle while ram_read_en=1 -> next cycle out_valid=0, ram_level=0; subsequent push 0x5A pops 0x5A.
REQ-040 Random in_valid/out_ready (50%) for 10000 cycles against a scoreboard model -> zero mismatches, ram_level never exceeds 256.
